// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Drives a 4-digit multiplexed common-anode 7-segment display from four BCD
//   digits plus a per-digit decimal-point mask. One digit is lit per slot. Each
//   slot opens with a dead-time gap in which every anode is off, which stops
//   ghosting between neighbouring digits. All inputs are captured once per
//   frame, so a value that changes part-way through a scan never tears on the
//   display.
//
// Parameters:
//   REFRESH_DIV    clk cycles per digit slot (>= 4)
//   BLANK_CYCLES   anode-off cycles at the start of each slot (< REFRESH_DIV)
//   SEG_ACTIVE_LOW 1: seg/dp are driven low to light a segment
//   AN_ACTIVE_LOW  1: an bits are driven low to enable a digit
//
// Optional feature (compile-time macro SEG7_LEADING_ZERO_BLANK_EN):
//   When the macro is defined, leading zeros of the captured value are blanked:
//   thousands, then hundreds, then tens are suppressed while they and every
//   digit to their left are zero. The ones digit always shows. A blanked
//   digit keeps its anode off for the whole slot and slot timing does not
//   change. Without the macro all four digits are always shown.
//
// Ports:
//   clk_100MHz   in   1  system clock
//   reset_n      in   1  asynchronous active-low reset
//   ones         in   4  BCD digit 0 (rightmost)
//   tens         in   4  BCD digit 1
//   hundreds     in   4  BCD digit 2
//   thousands    in   4  BCD digit 3 (leftmost)
//   dp_mask      in   4  decimal point enable, bit i belongs to digit i
//   seg          out  7  segments, seg[0]=a .. seg[6]=g
//   dp           out  1  decimal-point segment
//   an           out  4  digit enables, an[i] drives digit i
//   frame_start  out  1  one-cycle pulse on the cycle the snapshot is taken
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] dp_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(REFRESH_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_LIT   = CNT_W'(BLANK_CYCLES);
  localparam logic [1:0]       LAST_SLOT = 2'd3;

  // Inactive (dark) levels of each output group
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  // BCD to active-high gfedcba pattern; 10..15 show a dash (segment g)
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_bcd);
    logic [6:0] w_pat;
    case (i_bcd)
      4'd0:    w_pat = 7'h3F;
      4'd1:    w_pat = 7'h06;
      4'd2:    w_pat = 7'h5B;
      4'd3:    w_pat = 7'h4F;
      4'd4:    w_pat = 7'h66;
      4'd5:    w_pat = 7'h6D;
      4'd6:    w_pat = 7'h7D;
      4'd7:    w_pat = 7'h07;
      4'd8:    w_pat = 7'h7F;
      4'd9:    w_pat = 7'h6F;
      default: w_pat = 7'h40;
    endcase
    return w_pat;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_slot;
  logic [3:0][3:0]  r_snap_digit;   // index 0 = ones .. 3 = thousands
  logic [3:0]       r_snap_dp;
  logic             r_frame_start;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [3:0][3:0] w_in_digit;
  logic            w_cnt_last;
  logic            w_frame_end;
  logic            w_frame_pre;
  logic            w_in_gap;
  logic [3:0][6:0] w_pat;
  logic [3:0]      w_blank;

  assign w_in_digit  = {thousands, hundreds, tens, ones};
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_last && (r_slot == LAST_SLOT);
  // frame_start is a register that must be high on the snapshot cycle itself,
  // so it is loaded one cycle earlier.
  assign w_frame_pre = (r_cnt == CNT_PRE) && (r_slot == LAST_SLOT);
  assign w_in_gap    = (BLANK_CYCLES != 0) && (r_cnt < CNT_LIT);

  // One decoder per snapshot digit; the slot mux then picks a pattern
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
      assign w_pat[gi] = bcd_to_seg(r_snap_digit[gi]);
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [3:0] w_is_zero;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_zero
      assign w_is_zero[gi] = (r_snap_digit[gi] == 4'd0);
    end
  endgenerate

  // A digit is a leading zero only if everything to its left is blank too
  assign w_blank[3] = w_is_zero[3];
  assign w_blank[2] = w_blank[3] & w_is_zero[2];
  assign w_blank[1] = w_blank[2] & w_is_zero[1];
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = 4'b0000;
`endif

  // ---------------------------------------------------------------------------
  // Next output values, derived from the current counter and snapshot
  // ---------------------------------------------------------------------------
  logic [6:0] w_slot_pat;
  logic       w_dp_lit;
  logic [3:0] w_an_lit;
  logic [6:0] w_seg_next;
  logic       w_dp_next;
  logic [3:0] w_an_next;

  always_comb begin
    w_slot_pat = w_pat[r_slot];
    w_dp_lit   = r_snap_dp[r_slot];
    w_an_lit   = 4'b0000;
    // Only the current slot's anode can ever be enabled, so at most one bit
    if (!w_in_gap && !w_blank[r_slot]) begin
      w_an_lit = 4'b0001 << r_slot;
    end
    w_seg_next = SEG_ACTIVE_LOW ? ~w_slot_pat : w_slot_pat;
    w_dp_next  = SEG_ACTIVE_LOW ? ~w_dp_lit   : w_dp_lit;
    w_an_next  = AN_ACTIVE_LOW  ? ~w_an_lit   : w_an_lit;
  end

  // ---------------------------------------------------------------------------
  // Slot counter, frame snapshot and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_slot        <= 2'd0;
      r_snap_digit  <= '0;
      r_snap_dp     <= 4'b0000;
      r_frame_start <= 1'b0;
      r_seg         <= SEG_OFF;
      r_dp          <= DP_OFF;
      r_an          <= AN_OFF;
    end else begin
      if (w_cnt_last) begin
        r_cnt  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end

      // The only place the snapshot is written: end of the last slot
      if (w_frame_end) begin
        r_snap_digit <= w_in_digit;
        r_snap_dp    <= dp_mask;
      end

      r_frame_start <= w_frame_pre;
      r_seg         <= w_seg_next;
      r_dp          <= w_dp_next;
      r_an          <= w_an_next;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Reference model: display behaviour is predicted from the number of clock
// edges since reset release (slot = edge/DIV mod 4, position = edge mod DIV)
// and a copy of the inputs taken at every frame boundary.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0, thousands = 4'd0;
  logic [3:0] dp_mask = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV   (DIV),
    .BLANK_CYCLES  (BLANK),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Model state
  int         edge_n = 0;        // clock edges since reset release
  int         first_fs = -1;     // edge at which frame_start was first seen
  logic [3:0] m_dig [4];
  logic [3:0] m_dp;

  task automatic model_reset();
    edge_n   = 0;
    first_fs = -1;
    for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
    m_dp = 4'd0;
  endtask

  task automatic check_inactive(input string tag);
    check_val({tag, "_an"},  32'(an),          32'hF);
    check_val({tag, "_seg"}, 32'(seg),         32'h7F);
    check_val({tag, "_dp"},  32'(dp),          32'h1);
    check_val({tag, "_fs"},  32'(frame_start), 32'h0);
  endtask

  // Advance one clock and compare every output against the model
  task automatic step();
    int         s, slot, pos;
    bit         lz;
    logic [3:0] oh;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fs;
    @(posedge clk);
    edge_n++;
    // Outputs now reflect the position one edge earlier
    s    = edge_n - 1;
    slot = (s / DIV) % 4;
    pos  = s % DIV;
    lz   = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (slot != 0) begin
      lz = 1'b1;
      for (int k = 3; k >= slot; k--) if (m_dig[k] != 4'd0) lz = 1'b0;
    end
`endif
    oh      = 4'b0001 << slot;
    exp_an  = (pos >= BLANK && !lz) ? ~oh : 4'hF;
    exp_seg = ~SEG_TAB[m_dig[slot]];
    exp_dp  = ~m_dp[slot];
    exp_fs  = ((edge_n % FRAME) == FRAME - 1);
    // Inputs present at each frame boundary become visible from here on
    if ((edge_n % FRAME) == 0) begin
      m_dig[0] = ones; m_dig[1] = tens; m_dig[2] = hundreds; m_dig[3] = thousands;
      m_dp     = dp_mask;
    end
    #1;
    if (frame_start && first_fs < 0) first_fs = edge_n;
    check_val("an",          32'(an),          32'(exp_an));
    check_val("seg",         32'(seg),         32'(exp_seg));
    check_val("dp",          32'(dp),          32'(exp_dp));
    check_val("frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                       input logic [3:0] on, input logic [3:0] dm);
    thousands = th; hundreds = hu; tens = te; ones = on; dp_mask = dm;
    $display("apply digits=%0h%0h%0h%0h dp_mask=%b at edge %0d", th, hu, te, on, dm, edge_n);
  endtask

  // Reset asserted part-way through a clock cycle, held across n rising edges
  task automatic pulse_reset(input int n);
    reset_n = 1'b0;
    #1;
    check_inactive("rst_async");
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_inactive("rst_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  initial begin
    model_reset();
    #1;
    // Initial reset, held for 5 cycles
    pulse_reset(5);

    // First frame must still show zeros although new digits are applied
    apply(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    run(FRAME);
    check_val("first_frame_start", 32'(first_fs), 32'd31);

    // Frame displaying 1,2,3,4
    run(FRAME + 4);

    // Mid-frame change of ones stays invisible until the next snapshot
    apply(4'd1, 4'd2, 4'd3, 4'd7, 4'b0000);
    run(FRAME + 4);

    // Non-BCD ones digit with decimal point on digit 0
    apply(4'd1, 4'd2, 4'd3, 4'hC, 4'b0001);
    run(2 * FRAME);

    // Leading zeros
    apply(4'd0, 4'd0, 4'd4, 4'd0, 4'b0000);
    run(2 * FRAME);

    // Reset in the middle of slot 2 for one cycle
    while ((edge_n % FRAME) != 2 * DIV + 3) step();
    pulse_reset(1);
    run(2 * FRAME + 5);
    check_val("fs_after_reset", 32'(first_fs), 32'd31);

    // Randomised frames, including mid-frame changes and occasional resets
    for (int f = 0; f < 24; f++) begin
      int split;
      logic [3:0] d [4];
      for (int k = 0; k < 4; k++)
        d[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      apply(d[3], d[2], d[1], d[0], 4'($urandom_range(0, 15)));
      split = $urandom_range(1, FRAME - 1);
      run(split);
      if ($urandom_range(0, 5) == 0) begin
        pulse_reset($urandom_range(1, 3));
      end else begin
        apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      end
      run(FRAME - split + $urandom_range(0, 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
